tick_timer: RTL
===============

// Module: tick_timer
// PURPOSE
//  Programmable event timer that consumes the carry-out tick (COUT) of the 4-bit
//  free-running prescale counter, which is wired to TICK. It counts TICK pulses up
//  to a programmed limit, then raises a valid/ready event. One-shot and periodic
//  modes are supported. It reports a sticky overrun when an event is lost.
// PARAMETERS
//  WIDTH     8   width of LIMIT and COUNT; terminal count range 1..2**WIDTH
// PORTS
//  CLK          in   1      clock; all state updates on rising edge
//  ASYNCRESETN  in   1      asynchronous active-low reset
//  TICK         in   1      count-enable pulse (prescaler COUT); one tick per cycle high
//  START        in   1      1-cycle strobe: latch LIMIT/PERIODIC, clear COUNT/OVERRUN, run
//  STOP         in   1      1-cycle strobe: return to IDLE; a pending event is kept
//  PERIODIC     in   1      1 = reload and keep running after event; 0 = one-shot
//  LIMIT        in   WIDTH  terminal count in ticks; 0 encodes 2**WIDTH
//  COUNT        out  WIDTH  ticks counted since start or last wrap
//  BUSY         out  1      high in RUN state
//  EVT_VALID    out  1      event pending
//  EVT_READY    in   1      consumer accepts event when EVT_VALID & EVT_READY
//  OVERRUN      out  1      sticky: an event fired while the previous one was unaccepted
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, COUNT=0, BUSY=0, EVT_VALID=0,
//    OVERRUN=0, limit_q=0, periodic_q=0.
//  FSM states: IDLE, RUN (2 states; event pending tracked separately by EVT_VALID).
//    IDLE: TICK ignored, COUNT held. START -> RUN.
//    RUN: START restarts (COUNT<=0, relatch). STOP -> IDLE, COUNT held.
//  Priority in one cycle: STOP > START > TICK.
//  Count rule in RUN with TICK=1: if COUNT == limit_q-1 (mod 2**WIDTH), this is the
//    terminal tick. Else COUNT <= COUNT+1.
//  Terminal tick: COUNT <= 0; EVT_VALID <= 1 next cycle (1-cycle latency from TICK);
//    one-shot -> IDLE; periodic -> remain RUN.
//  LIMIT=1: every TICK is terminal. LIMIT=0: 2**WIDTH ticks, wrap of COUNT is terminal.
//  Handshake: EVT_VALID holds until the cycle with EVT_READY=1, then clears. EVT_READY is
//    ignored while EVT_VALID=0. There is no combinational READY->VALID path.
//  Terminal tick while EVT_VALID=1:
//    if EVT_READY=1 in that cycle, the old event is accepted and the new event stays
//    pending (VALID stays 1), OVERRUN unchanged.
//    else OVERRUN <= 1; VALID stays 1; the events merge.
//  OVERRUN is cleared only by START or reset. STOP does not clear EVT_VALID or OVERRUN.
//  START in the same cycle as a terminal tick: restart wins, no event is generated.
//  LIMIT and PERIODIC are sampled only at START; later changes have no effect until
//    the next START.
//  Reset mid-run or with event pending: all outputs return to reset values immediately.
//    The pending event is lost.
// STRUCTURE
//  Shared package: state enum {IDLE, RUN} as localparams; 1-bit encoding constants.
//  Sub-module tick_timer_core: WIDTH-bit loadable counter with terminal-compare output.
//  Top level: FSM, limit/mode latch, event/overrun register.
// TESTING
//  T1 reset: assert ASYNCRESETN=0 mid-run with EVT_VALID=1 -> all outputs 0 same cycle.
//  T2 one-shot: LIMIT=3, START, TICK every 2nd cycle -> EVT_VALID rises the cycle after
//     the 3rd TICK; BUSY=0; COUNT=0.
//  T3 periodic: LIMIT=4, TICK continuous, EVT_READY=1 -> one event per 4 cycles, 10
//     periods, OVERRUN=0.
//  T4 overrun: LIMIT=1, TICK continuous, EVT_READY=0 -> VALID after cycle 1, OVERRUN set
//     at 2nd tick; READY then clears VALID; OVERRUN stays 1 until START.
//  T5 boundary: LIMIT=0, WIDTH=8 -> event exactly after 256 ticks.
//  T5 collision: START with the terminal tick yields no event.
//  T5 priority: START+STOP together -> IDLE.
//  T6 random: constrained-random TICK/READY/START/STOP vs reference model; OVERRUN and
//     event counts match.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// -----------------------------------------------------------------------------
// tick_timer_pkg
//   Shared definitions for the tick timer: the two-state run/idle encoding and
//   the 1-bit constants used when driving control flags.
// -----------------------------------------------------------------------------
package tick_timer_pkg;

   // Run state of the timer. Event pending is tracked outside this FSM.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic BIT_ON  = 1'b1;
   localparam logic BIT_OFF = 1'b0;

endpackage : tick_timer_pkg

// File: rtl/tick_timer_core.sv
// -----------------------------------------------------------------------------
// tick_timer_core
//   WIDTH-bit loadable tick counter with terminal-count compare.
//   Ports:
//     clk_i      clock
//     rst_ni     asynchronous active-low reset
//     clr_i      synchronous clear of the count (wins over inc_i)
//     inc_i      advance by one tick; wraps to zero on the terminal tick
//     limit_i    terminal count in ticks, 0 encodes 2**WIDTH
//     count_o    current count
//     at_term_o  count is at limit-1, so the next tick is terminal
// -----------------------------------------------------------------------------
module tick_timer_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [WIDTH-1:0] limit_i,
   output logic [WIDTH-1:0] count_o,
   output logic             at_term_o
);
   import tick_timer_pkg::*;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] term_val;

   // limit-1 taken modulo 2**WIDTH: LIMIT=0 gives all-ones, i.e. 2**WIDTH ticks.
   assign term_val  = limit_i - ONE;
   assign at_term_o = (count_q == term_val) ? BIT_ON : BIT_OFF;
   assign count_o   = count_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = at_term_o ? '0 : (count_q + ONE);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : tick_timer_core

// File: rtl/tick_timer.sv
// -----------------------------------------------------------------------------
// tick_timer
//   Programmable event timer driven by prescaler carry ticks. Counts TICK pulses
//   up to a latched limit, then raises a valid/ready event. One-shot or periodic.
//   A sticky OVERRUN flags an event that fired while the previous one was still
//   unaccepted.
//   Ports:
//     CLK          clock
//     ASYNCRESETN  asynchronous active-low reset
//     TICK         count enable pulse
//     START        strobe: latch LIMIT/PERIODIC, clear COUNT/OVERRUN, run
//     STOP         strobe: return to idle, pending event kept
//     PERIODIC     1 = reload after event, 0 = one-shot
//     LIMIT        terminal count, 0 encodes 2**WIDTH
//     COUNT        ticks since start or last wrap
//     BUSY         high while running
//     EVT_VALID    event pending
//     EVT_READY    consumer accepts the pending event
//     OVERRUN      sticky lost-event flag
// -----------------------------------------------------------------------------
module tick_timer #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic             TICK,
   input  logic             START,
   input  logic             STOP,
   input  logic             PERIODIC,
   input  logic [WIDTH-1:0] LIMIT,
   output logic [WIDTH-1:0] COUNT,
   output logic             BUSY,
   output logic             EVT_VALID,
   input  logic             EVT_READY,
   output logic             OVERRUN
);
   import tick_timer_pkg::*;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic             periodic_q, periodic_d;
   logic             evt_q, evt_d;
   logic             ovr_q, ovr_d;

   logic             restart;
   logic             cnt_inc;
   logic             at_term;
   logic             term_tick;

   // STOP outranks START, which outranks TICK.
   assign restart   = START & ~STOP;
   assign cnt_inc   = (state_q == ST_RUN) & TICK & ~START & ~STOP;
   assign term_tick = cnt_inc & at_term;

   tick_timer_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk_i     (CLK),
      .rst_ni    (ASYNCRESETN),
      .clr_i     (restart),
      .inc_i     (cnt_inc),
      .limit_i   (limit_q),
      .count_o   (COUNT),
      .at_term_o (at_term)
   );

   always_comb begin
      state_d    = state_q;
      limit_d    = limit_q;
      periodic_d = periodic_q;
      evt_d      = evt_q;
      ovr_d      = ovr_q;

      if (STOP) begin
         state_d = ST_IDLE;
      end else if (START) begin
         state_d    = ST_RUN;
         limit_d    = LIMIT;
         periodic_d = PERIODIC;
      end else if (term_tick && !periodic_q) begin
         state_d = ST_IDLE;
      end

      // A new event merges into a pending one; it is only an overrun when the
      // pending one is not being accepted in the same cycle.
      if (term_tick) begin
         evt_d = BIT_ON;
         if (evt_q && !EVT_READY) begin
            ovr_d = BIT_ON;
         end
      end else if (evt_q && EVT_READY) begin
         evt_d = BIT_OFF;
      end

      if (restart) begin
         ovr_d = BIT_OFF;
      end
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q    <= ST_IDLE;
         limit_q    <= '0;
         periodic_q <= BIT_OFF;
         evt_q      <= BIT_OFF;
         ovr_q      <= BIT_OFF;
      end else begin
         state_q    <= state_d;
         limit_q    <= limit_d;
         periodic_q <= periodic_d;
         evt_q      <= evt_d;
         ovr_q      <= ovr_d;
      end
   end

   assign BUSY      = (state_q == ST_RUN);
   assign EVT_VALID = evt_q;
   assign OVERRUN   = ovr_q;

endmodule : tick_timer
